// File: rtl/wb_writeback_stage_if.sv
// MEM/WB bus for wb_writeback_stage: pipeline controls and operands in, register-file write port out.
// The master drives the i_* side and observes o_*; the stage itself uses the slave modport.
interface wb_writeback_stage_if #(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5,
  parameter int CNT_BITS  = 32
);
  // No valid/ready pair: i_valid marks a real instruction, i_stall is a hold
  // request (registers keep their value) and i_flush turns the next capture into a bubble.
  logic                 i_stall;
  logic                 i_flush;
  logic                 i_valid;
  logic                 i_RegWrite;
  logic                 i_MemToReg;
  logic                 i_JAL;
  logic [NREG_BITS-1:0] i_RegDst;
  logic [NBITS-1:0]     i_ALU_Result;
  logic [NBITS-1:0]     i_MemDatos;
  logic [NBITS-1:0]     i_PC_8;
  logic [1:0]           i_LoadSize;
  logic                 i_LoadUnsigned;
  logic [1:0]           i_ByteOffset;
  logic                 o_valid;
  logic                 o_RegWrite;
  logic [NREG_BITS-1:0] o_RegDst;
  logic [NBITS-1:0]     o_Registro;
  logic [CNT_BITS-1:0]  o_retired;

  modport master (
    output i_stall, i_flush, i_valid, i_RegWrite, i_MemToReg, i_JAL, i_RegDst,
           i_ALU_Result, i_MemDatos, i_PC_8, i_LoadSize, i_LoadUnsigned, i_ByteOffset,
    input  o_valid, o_RegWrite, o_RegDst, o_Registro, o_retired
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_RegWrite, i_MemToReg, i_JAL, i_RegDst,
           i_ALU_Result, i_MemDatos, i_PC_8, i_LoadSize, i_LoadUnsigned, i_ByteOffset,
    output o_valid, o_RegWrite, o_RegDst, o_Registro, o_retired
  );
endinterface

// File: rtl/wb_writeback_stage.sv
// MIPS MEM/WB register with write-data select (PC+8 / load / ALU) and a retired-write counter.
// Define WB_LOAD_EXT_EN to add byte/halfword extraction with sign/zero extension (requires NBITS=32).
module wb_writeback_stage #(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5,
  parameter int CNT_BITS  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_writeback_stage_if.slave  wb
);

  logic [NBITS-1:0]     load_val;
  logic [NBITS-1:0]     registro_d, registro_q;
  logic                 valid_d, valid_q;
  logic                 regwrite_d, regwrite_q;
  logic [NREG_BITS-1:0] regdst_d, regdst_q;
  logic [CNT_BITS-1:0]  retired_d, retired_q;
  logic                 wr_qual;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (wb.i_ByteOffset)
      2'd0:    byte_sel = wb.i_MemDatos[7:0];
      2'd1:    byte_sel = wb.i_MemDatos[15:8];
      2'd2:    byte_sel = wb.i_MemDatos[23:16];
      default: byte_sel = wb.i_MemDatos[31:24];
    endcase
    // Halfword offset bit 0 is ignored: misaligned halves are not trapped here.
    half_sel = wb.i_ByteOffset[1] ? wb.i_MemDatos[31:16] : wb.i_MemDatos[15:0];
    load_val = wb.i_MemDatos;
    case (wb.i_LoadSize)
      2'b00:   load_val = {{(NBITS-8){~wb.i_LoadUnsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{(NBITS-16){~wb.i_LoadUnsigned & half_sel[15]}}, half_sel};
      default: load_val = wb.i_MemDatos;
    endcase
  end
`else
  assign load_val = wb.i_MemDatos;
`endif

  assign wr_qual = wb.i_valid & wb.i_RegWrite & (wb.i_RegDst != '0);

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    regdst_d   = regdst_q;
    registro_d = registro_q;
    retired_d  = retired_q;
    if (wb.i_flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      regdst_d   = '0;
      registro_d = '0;
    end else if (!wb.i_stall) begin
      valid_d    = wb.i_valid;
      regwrite_d = wr_qual;
      regdst_d   = wb.i_RegDst;
      // JAL link beats MemToReg.
      if (wb.i_JAL)          registro_d = wb.i_PC_8;
      else if (wb.i_MemToReg) registro_d = load_val;
      else                   registro_d = wb.i_ALU_Result;
      if (wr_qual) retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      regdst_q   <= '0;
      registro_q <= '0;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      regdst_q   <= regdst_d;
      registro_q <= registro_d;
      retired_q  <= retired_d;
    end
  end

  assign wb.o_valid    = valid_q;
  assign wb.o_RegWrite = regwrite_q;
  assign wb.o_RegDst   = regdst_q;
  assign wb.o_Registro = registro_q;
  assign wb.o_retired  = retired_q;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Bench for wb_writeback_stage: directed plan plus random traffic against a reference model.
// A second instance with a 2-bit counter checks counter wrap-around.
module tb_wb_writeback_stage;

  logic i_clk;
  logic i_reset;

  wb_writeback_stage_if #(.NBITS(32), .NREG_BITS(5), .CNT_BITS(32)) bus ();
  wb_writeback_stage_if #(.NBITS(32), .NREG_BITS(5), .CNT_BITS(2))  bus_s ();

  wb_writeback_stage #(.NBITS(32), .NREG_BITS(5), .CNT_BITS(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .wb      (bus.slave)
  );

  wb_writeback_stage #(.NBITS(32), .NREG_BITS(5), .CNT_BITS(2)) dut_s (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .wb      (bus_s.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic        stall, flush, valid, rw, m2r, jal;
    logic [4:0]  dst;
    logic [31:0] alu, mem, pc8;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
  } stim_t;

  int checks   = 0;
  int failures = 0;
  logic [70:0] exp_q[$];

  // reference model state
  logic        m_valid, m_rw;
  logic [4:0]  m_dst;
  logic [31:0] m_reg, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] mem);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] sh;
    sh = mem >> (8 * off);
    b  = sh[7:0];
    h  = off[1] ? mem[31:16] : mem[15:0];
`ifdef WB_LOAD_EXT_EN
    if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return mem;
`else
    if (size == 2'b11 && uns && b == 8'h00 && h == 16'h0000) return mem;
    return mem;
`endif
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.stall = 0; s.flush = 0; s.valid = 0; s.rw = 0; s.m2r = 0; s.jal = 0;
    s.dst = 0; s.alu = 0; s.mem = 0; s.pc8 = 0; s.size = 2'b10; s.uns = 0; s.off = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.i_stall = s.stall;        bus_s.i_stall = s.stall;
    bus.i_flush = s.flush;        bus_s.i_flush = s.flush;
    bus.i_valid = s.valid;        bus_s.i_valid = s.valid;
    bus.i_RegWrite = s.rw;        bus_s.i_RegWrite = s.rw;
    bus.i_MemToReg = s.m2r;       bus_s.i_MemToReg = s.m2r;
    bus.i_JAL = s.jal;            bus_s.i_JAL = s.jal;
    bus.i_RegDst = s.dst;         bus_s.i_RegDst = s.dst;
    bus.i_ALU_Result = s.alu;     bus_s.i_ALU_Result = s.alu;
    bus.i_MemDatos = s.mem;       bus_s.i_MemDatos = s.mem;
    bus.i_PC_8 = s.pc8;           bus_s.i_PC_8 = s.pc8;
    bus.i_LoadSize = s.size;      bus_s.i_LoadSize = s.size;
    bus.i_LoadUnsigned = s.uns;   bus_s.i_LoadUnsigned = s.uns;
    bus.i_ByteOffset = s.off;     bus_s.i_ByteOffset = s.off;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_dst = 0; m_reg = 0; m_cnt = 0;
  endtask

  // ---------------- driver: one clock per call, scoreboarded ----------------
  task automatic drive(input stim_t s);
    logic [31:0] sel;
    logic        qual;
    logic [70:0] e;
    apply(s);
    sel  = s.jal ? s.pc8 : (s.m2r ? model_load(s.size, s.uns, s.off, s.mem) : s.alu);
    qual = s.valid & s.rw & (s.dst != 5'd0);
    if (s.flush) begin
      m_valid = 0; m_rw = 0; m_dst = 0; m_reg = 0;
    end else if (!s.stall) begin
      m_valid = s.valid; m_rw = qual; m_dst = s.dst; m_reg = sel;
      if (qual) m_cnt = m_cnt + 1;
    end
    exp_q.push_back({m_valid, m_rw, m_dst, m_reg, m_cnt});
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    check("valid",    {31'd0, bus.o_valid},    {31'd0, e[70]});
    check("regwrite", {31'd0, bus.o_RegWrite}, {31'd0, e[69]});
    check("regdst",   {27'd0, bus.o_RegDst},   {27'd0, e[68:64]});
    check("registro", bus.o_Registro,          e[63:32]);
    check("retired",  bus.o_retired,           e[31:0]);
    check("retired_wrap", {30'd0, bus_s.o_retired}, {30'd0, e[1:0]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    {31'd0, bus.o_valid},    32'd0);
    check({tag, "_regwrite"}, {31'd0, bus.o_RegWrite}, 32'd0);
    check({tag, "_regdst"},   {27'd0, bus.o_RegDst},   32'd0);
    check({tag, "_registro"}, bus.o_Registro,          32'd0);
    check({tag, "_retired"},  bus.o_retired,           32'd0);
    check({tag, "_retired_s"}, {30'd0, bus_s.o_retired}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    logic [31:0] lb_exp;
    i_reset = 1'b0;
    apply(idle());
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_reset = 1'b1;

    // ALU path
    s = idle(); s.valid = 1; s.rw = 1; s.dst = 8; s.alu = 32'h0000_1234;
    drive(s);
    check("plan_alu", bus.o_Registro, 32'h0000_1234);
    check("plan_alu_cnt", bus.o_retired, 32'd1);

    // JAL beats MemToReg
    s = idle(); s.valid = 1; s.rw = 1; s.jal = 1; s.m2r = 1; s.dst = 31;
    s.pc8 = 32'h0040_0010; s.mem = 32'hDEAD_BEEF; s.alu = 32'h1111_1111;
    drive(s);
    check("plan_jal", bus.o_Registro, 32'h0040_0010);

    // loads over one memory word
    s = idle(); s.valid = 1; s.rw = 1; s.m2r = 1; s.dst = 4; s.mem = 32'h80FF_7F81;
    s.size = 2'b00; s.uns = 0; s.off = 0; drive(s);
`ifdef WB_LOAD_EXT_EN
    lb_exp = 32'hFFFF_FF81;
`else
    lb_exp = 32'h80FF_7F81;
`endif
    check("plan_lb0", bus.o_Registro, lb_exp);
    s.uns = 1; drive(s);
    s.uns = 0; s.off = 1; drive(s);
    s.size = 2'b01; s.off = 2; drive(s);
    s.off = 3; drive(s);
    s.uns = 1; s.off = 0; drive(s);
    s.size = 2'b00; s.off = 3; drive(s);
    s.size = 2'b11; s.off = 1; drive(s);

    // $0 suppression
    s = idle(); s.valid = 1; s.rw = 1; s.dst = 0; s.alu = 32'h5555_AAAA;
    drive(s);
    check("plan_r0_we", {31'd0, bus.o_RegWrite}, 32'd0);

    // valid low or RegWrite low: no write
    s = idle(); s.valid = 0; s.rw = 1; s.dst = 3; s.alu = 32'h1; drive(s);
    s = idle(); s.valid = 1; s.rw = 0; s.dst = 3; s.alu = 32'h2; drive(s);

    // stall holds for 3 cycles while inputs change, then flush+stall
    s = idle(); s.valid = 1; s.rw = 1; s.dst = 9; s.alu = 32'h0000_0909; drive(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1; s.valid = 1; s.rw = 1; s.dst = 5'(10 + i);
      s.alu = $urandom(); drive(s);
      check("plan_stall_hold", bus.o_Registro, 32'h0000_0909);
    end
    s = idle(); s.stall = 1; s.flush = 1; s.valid = 1; s.rw = 1; s.dst = 7; s.alu = 32'h7;
    drive(s);
    check("plan_flush_we", {31'd0, bus.o_RegWrite}, 32'd0);

    // counter wrap on the 2-bit instance: several back-to-back writes
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.valid = 1; s.rw = 1; s.dst = 5'(1 + i); s.alu = 32'(i); drive(s);
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      s.stall = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 4) != 0);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.m2r   = $urandom_range(0, 1);
      s.jal   = ($urandom_range(0, 5) == 0);
      s.dst   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.alu   = $urandom();
      s.mem   = $urandom();
      s.pc8   = $urandom();
      s.size  = 2'($urandom_range(0, 3));
      s.uns   = $urandom_range(0, 1);
      s.off   = 2'($urandom_range(0, 3));
      drive(s);
    end

    // async reset mid-stall, between edges
    s = idle(); s.valid = 1; s.rw = 1; s.dst = 12; s.alu = 32'hCAFE_0012; drive(s);
    s.stall = 1; drive(s);
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    @(negedge i_clk);
    i_reset = 1'b1;
    s = idle(); s.stall = 1; drive(s);
    s = idle(); s.valid = 1; s.rw = 1; s.dst = 2; s.alu = 32'h0000_0002; drive(s);
    check("post_reset_cnt", bus.o_retired, 32'd1);

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
